// File: rtl/ir_pkg.sv
// Shared opcode map and immediate-extension helper for the prefetching decoder.
package ir_pkg;

  localparam int OP_NOP  = 0;
  localparam int OP_LD   = 1;
  localparam int OP_LN   = 2;
  localparam int OP_CP   = 3;
  localparam int OP_ST   = 4;
  localparam int OP_SHL  = 5;
  localparam int OP_ADD  = 6;
  localparam int OP_SUB  = 7;
  localparam int OP_JZ   = 8;
  localparam int OP_JB   = 9;
  localparam int OP_JMP  = 10;
  localparam int OP_XOR  = 11;
  localparam int OP_OR   = 12;
  localparam int OP_AND  = 13;
  localparam int OP_SHR  = 14;
  localparam int OP_NOT  = 15;
  localparam int OP_PUSH = 16;
  localparam int OP_POP  = 17;

  localparam int NUM_OPS_DEFAULT = 18;

  // Extends the low imm_w bits of raw to 64 bits; callers truncate to their bus width.
  function automatic logic [63:0] ext_imm(input logic [63:0] raw, input int imm_w,
                                          input bit sign_ext);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < imm_w) res[i] = raw[i];
      else           res[i] = sign_ext & raw[imm_w-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/ir_prefetch_decode_if.sv
// Fetch-side valid/ready handshake between the fetch unit and the prefetch queue.
interface ir_prefetch_decode_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] code;

  modport master (output in_valid, output code, input in_ready);
  modport slave  (input in_valid, input code, output in_ready);
endinterface

// File: rtl/ir_fifo.sv
// DATA_W x DEPTH circular prefetch buffer with push/pop/flush and occupancy count.
module ir_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Flush wins over both sides; a full queue never accepts, even when popping.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ir_prefetch_decode.sv
// Prefetch queue in front of a registered one-hot opcode decoder with tristate immediate drive.
module ir_prefetch_decode
  import ir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int OP_W     = 5,
  parameter int NUM_OPS  = NUM_OPS_DEFAULT,
  parameter int IMM_W    = 8,
  parameter int DEPTH    = 2,
  parameter int SIGN_EXT = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  ir_prefetch_decode_if.slave fetch,
  input  logic                iir,
  input  logic                eir,
  input  logic                flush,
  inout  wire  [DATA_W-1:0]   data,
  output logic [NUM_OPS-1:0]  op_onehot,
  output logic                op_valid,
  output logic                illegal,
  output logic [DATA_W-1:0]   o_buff_data,
  output logic [DATA_W-1:0]   o_buff_code,
  output logic [CNT_W-1:0]    q_count
);

  logic [DATA_W-1:0]  head;
  logic               q_full, q_empty;
  logic [OP_W-1:0]    opcode;

  logic [NUM_OPS-1:0] op_onehot_q, op_onehot_d;
  logic               op_valid_q, op_valid_d;
  logic               illegal_q, illegal_d;
  logic [DATA_W-1:0]  buff_data_q, buff_data_d;
  logic [DATA_W-1:0]  buff_code_q, buff_code_d;
  logic               drive_en_q, drive_en_d;
  logic [DATA_W-1:0]  drive_val_q, drive_val_d;

  ir_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch.in_valid),
    .wdata (fetch.code),
    .pop   (iir),
    .flush (flush),
    .rdata (head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign fetch.in_ready = !q_full;
  assign opcode         = head[DATA_W-1 -: OP_W];

  always_comb begin
    op_onehot_d = op_onehot_q;
    op_valid_d  = op_valid_q;
    illegal_d   = illegal_q;
    buff_data_d = buff_data_q;
    buff_code_d = buff_code_q;
    if (flush || (iir && q_empty)) begin
      op_onehot_d = NUM_OPS'(1);
      op_valid_d  = 1'b0;
      illegal_d   = 1'b0;
    end else if (iir) begin
      buff_code_d = head;
      buff_data_d = DATA_W'(ext_imm(64'(head[IMM_W-1:0]), IMM_W, SIGN_EXT != 0));
      op_valid_d  = 1'b1;
      if (int'(opcode) < NUM_OPS) begin
        op_onehot_d = NUM_OPS'(1) << opcode;
        illegal_d   = 1'b0;
      end else begin
        op_onehot_d = NUM_OPS'(1);
        illegal_d   = 1'b1;
      end
    end
  end

  // The bus samples the immediate before this edge's decode update, so iir+eir shows the old one.
  assign drive_en_d  = eir;
  assign drive_val_d = buff_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_onehot_q <= NUM_OPS'(1);
      op_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      buff_data_q <= '0;
      buff_code_q <= '0;
      drive_en_q  <= 1'b0;
      drive_val_q <= '0;
    end else begin
      op_onehot_q <= op_onehot_d;
      op_valid_q  <= op_valid_d;
      illegal_q   <= illegal_d;
      buff_data_q <= buff_data_d;
      buff_code_q <= buff_code_d;
      drive_en_q  <= drive_en_d;
      drive_val_q <= drive_val_d;
    end
  end

  assign op_onehot   = op_onehot_q;
  assign op_valid    = op_valid_q;
  assign illegal     = illegal_q;
  assign o_buff_data = buff_data_q;
  assign o_buff_code = buff_code_q;
  assign data        = drive_en_q ? drive_val_q : {DATA_W{1'bz}};

endmodule
